// File: rtl/arb_param.sv
`default_nettype none
// ============================================================================
//  Module   : arb_param
//  Brief    : N-way arbiter with run-time fixed/round-robin priority,
//             multi-cycle grant ownership bounded by a hold limit, and a
//             guaranteed one-cycle idle gap between consecutive grants.
//  Revision : 1.0  initial release
// ============================================================================
module arb_param #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rr_en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  // Hold counter is wide enough to reach HOLD_MAX; one bit when unlimited.
  localparam int HCW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic           busy_nxt;
  logic           timeout_nxt;

  logic [IDW-1:0] win;
  logic           win_vld;
  logic           rel_drop;
  logic           rel_to;

  // Winner search: scan N positions upward from the start index with wrap;
  // fixed mode starts at 0, round-robin starts at the pointer.
  always_comb begin : p_winner
    logic [IDW:0] start;
    logic [IDW:0] sum;
    logic [IDW-1:0] idx;
    win     = '0;
    win_vld = 1'b0;
    start   = rr_en ? {1'b0, ptr} : '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      sum = start + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N)) begin
        sum = sum - (IDW+1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign rel_drop = !req[gnt_id];

  generate
    if (HOLD_MAX == 0) begin : g_no_limit
      assign rel_to = 1'b0;
    end else begin : g_limit
      assign rel_to = (hold_cnt == HCW'(HOLD_MAX));
    end
  endgenerate

  // Next-state and next-output decode; every register value is computed here.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = '0;
    gnt_nxt     = '0;
    gnt_id_nxt  = '0;
    busy_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt       = GRANT;
          gnt_nxt[win]    = 1'b1;
          gnt_id_nxt      = win;
          busy_nxt        = 1'b1;
          hold_nxt        = HCW'(1);
          ptr_nxt         = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
        end
      end
      GRANT: begin
        if (rel_drop || rel_to) begin
          // Simultaneous drop and expiry is an ordinary release.
          state_nxt   = IDLE;
          timeout_nxt = rel_to && !rel_drop;
        end else begin
          gnt_nxt    = gnt;
          gnt_id_nxt = gnt_id;
          busy_nxt   = 1'b1;
          hold_nxt   = (&hold_cnt) ? hold_cnt : hold_cnt + HCW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule
`default_nettype wire
